if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage pipelined RISC-V core. It sits directly upstream of the decode stage.
- Owns the PC register and drives the instruction-memory address. Registers the IF/ID pipeline outputs.
- Predicts next PC with a direct-mapped BTB carrying 2-bit saturating counters. Takes stall from the hazard unit and flush/redirect from EX branch resolution.

---
 rtl/if_stage.sv | 136 +++++++++++++
 tb/tb_if_stage.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: RISC-V instruction fetch with PC, IF/ID register and a direct-mapped
// BTB of 2-bit saturating counters; flush redirects, stall holds.
module if_stage #(
    parameter int unsigned BTB_IDX_BITS = 4,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] NOP_INST     = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid,
    output logic        if_id_pred_taken,
    output logic [31:0] if_id_pred_target
);
    localparam int unsigned ENTRIES = 1 << BTB_IDX_BITS;
    localparam int unsigned TAG_W   = 30 - BTB_IDX_BITS;

    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        valid_q, valid_d;
    logic        pt_q, pt_d;
    logic [31:0] ptgt_q, ptgt_d;

    logic [ENTRIES-1:0] btb_v_q, btb_v_d;
    logic [TAG_W-1:0]   btb_tag_q [ENTRIES];
    logic [TAG_W-1:0]   btb_tag_d [ENTRIES];
    logic [31:0]        btb_tgt_q [ENTRIES];
    logic [31:0]        btb_tgt_d [ENTRIES];
    logic [1:0]         btb_ctr_q [ENTRIES];
    logic [1:0]         btb_ctr_d [ENTRIES];

    logic [BTB_IDX_BITS-1:0] idx, uidx;
    logic                    hit, uhit, pred_taken;
    logic [31:0]             pred_next;
    logic [1:0]              uctr;
    logic                    unused_upd_lsb;

    assign unused_upd_lsb = ^upd_pc[1:0];

    // Lookup always reads the pre-update contents.
    assign idx        = pc_q[BTB_IDX_BITS+1:2];
    assign hit        = btb_v_q[idx] && (btb_tag_q[idx] == pc_q[31:BTB_IDX_BITS+2]);
    assign pred_taken = hit && btb_ctr_q[idx][1];
    assign pred_next  = pred_taken ? btb_tgt_q[idx] : pc_q + 32'd4;

    assign uidx = upd_pc[BTB_IDX_BITS+1:2];
    assign uhit = btb_v_q[uidx] && (btb_tag_q[uidx] == upd_pc[31:BTB_IDX_BITS+2]);
    assign uctr = btb_ctr_q[uidx];

    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        id_pc_d = id_pc_q;
        valid_d = valid_q;
        pt_d    = pt_q;
        ptgt_d  = ptgt_q;
        if (flush) begin
            pc_d    = redirect_pc;
            inst_d  = NOP_INST;
            id_pc_d = 32'd0;
            valid_d = 1'b0;
            pt_d    = 1'b0;
            ptgt_d  = 32'd0;
        end else if (!stall) begin
            pc_d    = pred_next;
            inst_d  = imem_inst;
            id_pc_d = pc_q;
            valid_d = 1'b1;
            pt_d    = pred_taken;
            ptgt_d  = pred_next;
        end
    end

    // Training ignores stall/flush: EX resolution is never lost.
    always_comb begin
        btb_v_d   = btb_v_q;
        btb_tag_d = btb_tag_q;
        btb_tgt_d = btb_tgt_q;
        btb_ctr_d = btb_ctr_q;
        if (upd_valid && uhit) begin
            btb_tgt_d[uidx] = upd_taken ? upd_target : btb_tgt_q[uidx];
            btb_ctr_d[uidx] = upd_taken ? ((uctr == 2'd3) ? 2'd3 : uctr + 2'd1)
                                        : ((uctr == 2'd0) ? 2'd0 : uctr - 2'd1);
        end else if (upd_valid && upd_taken) begin
            btb_v_d[uidx]   = 1'b1;
            btb_tag_d[uidx] = upd_pc[31:BTB_IDX_BITS+2];
            btb_tgt_d[uidx] = upd_target;
            btb_ctr_d[uidx] = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            id_pc_q <= 32'd0;
            valid_q <= 1'b0;
            pt_q    <= 1'b0;
            ptgt_q  <= 32'd0;
            btb_v_q <= '0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            id_pc_q <= id_pc_d;
            valid_q <= valid_d;
            pt_q    <= pt_d;
            ptgt_q  <= ptgt_d;
            btb_v_q <= btb_v_d;
        end
    end

    // Payload needs no reset; valid bits gate it.
    always_ff @(posedge clk) begin
        btb_tag_q <= btb_tag_d;
        btb_tgt_q <= btb_tgt_d;
        btb_ctr_q <= btb_ctr_d;
    end

    assign imem_addr         = pc_q;
    assign if_id_inst        = inst_q;
    assign if_id_pc          = id_pc_q;
    assign if_id_valid       = valid_q;
    assign if_id_pred_taken  = pt_q;
    assign if_id_pred_target = ptgt_q;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: table-driven vectors with a scoreboard queue for if_stage.
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] XK  = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        reset, stall, flush, upd_valid, upd_taken;
    logic [31:0] redirect_pc, upd_pc, upd_target, imem_addr, imem_inst;
    logic [31:0] if_id_inst, if_id_pc, if_id_pred_target;
    logic        if_id_valid, if_id_pred_taken;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        rst, stl, fl;
        logic [31:0] rpc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utg;
        logic [31:0] addr, ipc;
        logic        iv, ipt;
        logic [31:0] iptg;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    // Instruction memory model: each word is a recognisable function of its address.
    assign imem_inst = imem_addr ^ XK;

    if_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .imem_addr(imem_addr), .imem_inst(imem_inst), .if_id_inst(if_id_inst),
        .if_id_pc(if_id_pc), .if_id_valid(if_id_valid), .if_id_pred_taken(if_id_pred_taken),
        .if_id_pred_target(if_id_pred_target)
    );

    function automatic vec_t mk(input logic rst, stl, fl, input logic [31:0] rpc,
                                input logic uv, input logic [31:0] upc, input logic ut,
                                input logic [31:0] utg, input logic [31:0] addr, ipc,
                                input logic iv, ipt, input logic [31:0] iptg);
        vec_t v;
        v.rst = rst; v.stl = stl; v.fl = fl; v.rpc = rpc;
        v.uv = uv; v.upc = upc; v.ut = ut; v.utg = utg;
        v.addr = addr; v.ipc = ipc; v.iv = iv; v.ipt = ipt; v.iptg = iptg;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; stall = v.stl; flush = v.fl; redirect_pc = v.rpc;
        upd_valid = v.uv; upd_pc = v.upc; upd_taken = v.ut; upd_target = v.utg;
    endtask

    task automatic cmp(input string tag, input vec_t e);
        chk({tag, " imem_addr"}, imem_addr, e.addr);
        chk({tag, " if_id_pc"}, if_id_pc, e.ipc);
        chk({tag, " if_id_valid"}, {31'd0, if_id_valid}, {31'd0, e.iv});
        chk({tag, " if_id_inst"}, if_id_inst, e.iv ? (e.ipc ^ XK) : NOP);
        chk({tag, " pred_taken"}, {31'd0, if_id_pred_taken}, {31'd0, e.ipt});
        chk({tag, " pred_target"}, if_id_pred_target, e.iptg);
    endtask

    initial begin
        vec_t e, h;
        //             rst stl fl rpc           uv upc        ut utg            addr          ipc           iv pt ptgt
        tbl.push_back(mk(0, 0, 0, 0,            0, 0,         0, 0,             32'h4,        32'h0,        1, 0, 32'h4));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0,         0, 0,             32'h8,        32'h4,        1, 0, 32'h8));
        tbl.push_back(mk(0, 1, 0, 0,            0, 0,         0, 0,             32'h8,        32'h4,        1, 0, 32'h8));
        tbl.push_back(mk(0, 1, 0, 0,            0, 0,         0, 0,             32'h8,        32'h4,        1, 0, 32'h8));
        tbl.push_back(mk(0, 1, 0, 0,            0, 0,         0, 0,             32'h8,        32'h4,        1, 0, 32'h8));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0,         0, 0,             32'hC,        32'h8,        1, 0, 32'hC));
        tbl.push_back(mk(0, 0, 0, 0,            1, 32'h10,    1, 32'h40,        32'h10,       32'hC,        1, 0, 32'h10));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0,         0, 0,             32'h40,       32'h10,       1, 1, 32'h40));
        tbl.push_back(mk(0, 0, 0, 0,            1, 32'h10,    0, 0,             32'h44,       32'h40,       1, 0, 32'h44));
        tbl.push_back(mk(0, 0, 0, 0,            1, 32'h10,    0, 0,             32'h48,       32'h44,       1, 0, 32'h48));
        tbl.push_back(mk(0, 0, 0, 0,            1, 32'h10,    0, 0,             32'h4C,       32'h48,       1, 0, 32'h4C));
        tbl.push_back(mk(0, 0, 1, 32'h10,       0, 0,         0, 0,             32'h10,       32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0,            1, 32'h10,    1, 32'h40,        32'h14,       32'h10,       1, 0, 32'h14));
        tbl.push_back(mk(0, 0, 0, 0,            1, 32'h10,    1, 32'h40,        32'h18,       32'h14,       1, 0, 32'h18));
        tbl.push_back(mk(0, 0, 1, 32'h10,       0, 0,         0, 0,             32'h10,       32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0,         0, 0,             32'h40,       32'h10,       1, 1, 32'h40));
        tbl.push_back(mk(0, 1, 1, 32'h100,      0, 0,         0, 0,             32'h100,      32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0,         0, 0,             32'h104,      32'h100,      1, 0, 32'h104));
        tbl.push_back(mk(0, 0, 1, 32'h20,       0, 0,         0, 0,             32'h20,       32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0,            1, 32'h20,    1, 32'h80,        32'h24,       32'h20,       1, 0, 32'h24));
        tbl.push_back(mk(0, 0, 1, 32'h20,       0, 0,         0, 0,             32'h20,       32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0,         0, 0,             32'h80,       32'h20,       1, 1, 32'h80));
        tbl.push_back(mk(0, 1, 0, 0,            1, 32'h30,    1, 32'h200,       32'h80,       32'h20,       1, 1, 32'h80));
        tbl.push_back(mk(0, 0, 1, 32'h30,       0, 0,         0, 0,             32'h30,       32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0,         0, 0,             32'h200,      32'h30,       1, 1, 32'h200));
        tbl.push_back(mk(0, 0, 0, 0,            1, 32'h50,    1, 32'h300,       32'h204,      32'h200,      1, 0, 32'h204));
        tbl.push_back(mk(0, 0, 1, 32'h10,       0, 0,         0, 0,             32'h10,       32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0,         0, 0,             32'h14,       32'h10,       1, 0, 32'h14));
        tbl.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 0, 0,        0, 0,             32'hFFFF_FFFC, 32'h0,       0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0,         0, 0,             32'h0,        32'hFFFF_FFFC, 1, 0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 0,            1, 32'h4,     1, 32'h500,       32'h0,        32'hFFFF_FFFC, 1, 0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 0,            0, 0,         0, 0,             32'h0,        32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0,         0, 0,             32'h4,        32'h0,        1, 0, 32'h4));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0,         0, 0,             32'h8,        32'h4,        1, 0, 32'h8));

        h = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        drive(h);
        repeat (2) @(posedge clk);
        #1 cmp("reset", h);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i]);
            sb.push_back(tbl[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            cmp($sformatf("row%0d", i), e);
        end

        // Reset beats a simultaneous flush, then fetch restarts at 0.
        @(negedge clk);
        h = mk(1, 0, 1, 32'h300, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        drive(h);
        @(posedge clk);
        #1 cmp("rst_flush", h);
        @(negedge clk);
        h = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h4, 32'h0, 1, 0, 32'h4);
        drive(h);
        @(posedge clk);
        #1 cmp("post_rst", h);

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
